// File: rtl/alu_scan_pkg.sv
// Shared definitions for the scan-testable two-stage ALU pipeline:
// op encodings, scan chain length, and the default MISR polynomial.
package alu_scan_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SHL  = 3'b101,
        OP_SHR  = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    localparam logic [7:0] MISR_POLY_DEFAULT = 8'hB8;

    // Stage 1 holds valid+op+a+b, stage 2 holds valid+carry+zero+result, MISR optional.
    function automatic int chain_len(input int width, input bit misr_en);
        return 7 + 3 * width + (misr_en ? width : 0);
    endfunction

endpackage

// File: rtl/alu_scan_opunit.sv
// Purely combinational ALU operation unit; all state lives in alu_scan_pipe.
module alu_scan_opunit
    import alu_scan_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] diff_s;

    // Operation decode; SUB carry is the inverted borrow, i.e. set when a >= b.
    always_comb begin
        sum_s  = {1'b0, a} + {1'b0, b};
        diff_s = {1'b0, a} - {1'b0, b};
        result = {WIDTH{1'b0}};
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum_s[WIDTH-1:0];
                carry  = sum_s[WIDTH];
            end
            OP_SUB: begin
                result = diff_s[WIDTH-1:0];
                carry  = ~diff_s[WIDTH];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL: begin
                result = {a[WIDTH-2:0], 1'b0};
                carry  = a[WIDTH-1];
            end
            OP_SHR: begin
                result = {1'b0, a[WIDTH-1:1]};
                carry  = a[0];
            end
            OP_PASS: result = a;
            default: begin
                result = {WIDTH{1'b0}};
                carry  = 1'b0;
            end
        endcase
    end

    assign zero = (result == {WIDTH{1'b0}});

endmodule

// File: rtl/alu_scan_pipe.sv
// Two-stage ALU pipeline whose flops form one muxed-D scan chain.
// Define ALU_SCAN_MISR_EN to add a result-compacting MISR and the signature port.
module alu_scan_pipe
    import alu_scan_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] MISR_POLY = WIDTH'(MISR_POLY_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scan_en,
    input  logic             scan_in,
    input  logic             in_valid,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
`ifdef ALU_SCAN_MISR_EN
    output logic [WIDTH-1:0] signature,
`endif
    output logic             scan_out
);

`ifdef ALU_SCAN_MISR_EN
    localparam bit MISR_EN = 1'b1;
`else
    localparam bit MISR_EN = 1'b0;
`endif
    localparam int MISR_W    = MISR_EN ? WIDTH : 0;
    localparam int CHAIN_LEN = chain_len(WIDTH, MISR_EN);
    localparam int STAGE_LEN = 7 + 3 * WIDTH;

    // Field positions inside the chain, LSB upward; MISR (if any) sits at the bottom.
    localparam int S2_RES_LO = MISR_W;
    localparam int S2_ZERO   = S2_RES_LO + WIDTH;
    localparam int S2_CARRY  = S2_ZERO + 1;
    localparam int S2_VALID  = S2_CARRY + 1;
    localparam int S1_B_LO   = S2_VALID + 1;
    localparam int S1_A_LO   = S1_B_LO + WIDTH;
    localparam int S1_OP_LO  = S1_A_LO + WIDTH;
    localparam int S1_VALID  = S1_OP_LO + 3;

    logic [CHAIN_LEN-1:0] chain_r;
    logic [CHAIN_LEN-1:0] chain_next_s;
    logic [STAGE_LEN-1:0] stage_next_s;

    logic             s1_valid_s;
    logic [2:0]       s1_op_s;
    logic [WIDTH-1:0] s1_a_s;
    logic [WIDTH-1:0] s1_b_s;
    logic             s2_valid_s;
    logic             s2_carry_s;
    logic             s2_zero_s;
    logic [WIDTH-1:0] s2_result_s;
    logic [WIDTH-1:0] op_result_s;
    logic             op_carry_s;
    logic             op_zero_s;

    assign s1_valid_s  = chain_r[S1_VALID];
    assign s1_op_s     = chain_r[S1_OP_LO +: 3];
    assign s1_a_s      = chain_r[S1_A_LO +: WIDTH];
    assign s1_b_s      = chain_r[S1_B_LO +: WIDTH];
    assign s2_valid_s  = chain_r[S2_VALID];
    assign s2_carry_s  = chain_r[S2_CARRY];
    assign s2_zero_s   = chain_r[S2_ZERO];
    assign s2_result_s = chain_r[S2_RES_LO +: WIDTH];

    alu_scan_opunit #(
        .WIDTH (WIDTH)
    ) u_opunit (
        .op     (op_e'(s1_op_s)),
        .a      (s1_a_s),
        .b      (s1_b_s),
        .result (op_result_s),
        .carry  (op_carry_s),
        .zero   (op_zero_s)
    );

    // Stage 2 loads regardless of s1_valid; only the valid bit qualifies the data.
    assign stage_next_s = {in_valid, op_code, a, b,
                           s1_valid_s, op_carry_s, op_zero_s, op_result_s};

`ifdef ALU_SCAN_MISR_EN
    logic [WIDTH-1:0] misr_s;
    logic [WIDTH-1:0] misr_next_s;

    assign misr_s = chain_r[WIDTH-1:0];

    // MISR compacts each valid stage-2 result, otherwise holds.
    always_comb begin
        if (s2_valid_s) begin
            misr_next_s = ({misr_s[WIDTH-2:0], 1'b0}
                           ^ (misr_s[WIDTH-1] ? MISR_POLY : {WIDTH{1'b0}}))
                          ^ s2_result_s;
        end else begin
            misr_next_s = misr_s;
        end
    end

    assign signature = misr_s;
`endif

    // Scan mode shifts the whole chain toward the MSB; otherwise functional update.
    always_comb begin
        chain_next_s = chain_r;
        if (scan_en) begin
            chain_next_s = {chain_r[CHAIN_LEN-2:0], scan_in};
        end else begin
`ifdef ALU_SCAN_MISR_EN
            chain_next_s = {stage_next_s, misr_next_s};
`else
            chain_next_s = stage_next_s;
`endif
        end
    end

    // Chain register; reset wins over both scan and functional update.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_r <= {CHAIN_LEN{1'b0}};
        end else begin
            chain_r <= chain_next_s;
        end
    end

    assign out_valid = s2_valid_s;
    assign result    = s2_result_s;
    assign carry     = s2_carry_s;
    assign zero      = s2_zero_s;
    assign scan_out  = chain_r[CHAIN_LEN-1];

endmodule
